// File: rtl/addsub_rr_sequencer_if.sv
// Requester, shared add/sub unit and result port bundle for addsub_rr_sequencer.
// slave is the sequencer's view; master is the environment's view.
interface addsub_rr_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid_in;
  logic [NREQ-1:0]       req_ready_out;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       control_in;
  logic [WIDTH-1:0]      au_a_out;
  logic [WIDTH-1:0]      au_b_out;
  logic                  au_control_out;
  logic [WIDTH-1:0]      au_sum_in;
  logic                  au_carry_in;
  logic                  result_valid_out;
  logic                  result_ready_in;
  logic [WIDTH-1:0]      sum_out;
  logic                  carry_out;
  logic [IDW-1:0]        result_id_out;
  logic                  busy_out;

  modport slave (
    input  req_valid_in, a_in, b_in, control_in, au_sum_in, au_carry_in, result_ready_in,
    output req_ready_out, au_a_out, au_b_out, au_control_out, result_valid_out, sum_out,
    output carry_out, result_id_out, busy_out
  );

  modport master (
    output req_valid_in, a_in, b_in, control_in, au_sum_in, au_carry_in, result_ready_in,
    input  req_ready_out, au_a_out, au_b_out, au_control_out, result_valid_out, sum_out,
    input  carry_out, result_id_out, busy_out
  );
endinterface

// File: rtl/addsub_rr_sequencer.sv
// Round-robin sequencer sharing one external add/sub unit among NREQ requesters.
// IDLE grants one requester, EXEC drives the unit and captures its result, DONE holds it.
module addsub_rr_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  addsub_rr_sequencer_if.slave   bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic [IDW-1:0]   last_grant_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             op_ctrl_q;
  logic [IDW-1:0]   op_id_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDW-1:0]   id_q;
  logic             valid_q;
  logic             busy_q;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand_idx;
  int unsigned      cand;
  logic             grant;
  logic [NREQ-1:0]  ready;

  // Scan starting just after the last winner so every requester gets its turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand     = (32'(last_grant_q) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!win_found && bus.req_valid_in[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    grant          = (state_q == StIdle) && !rst_in && win_found;
    ready          = '0;
    ready[win_idx] = grant;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      last_grant_q <= IDW'(NREQ - 1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_ctrl_q    <= 1'b0;
      op_id_q      <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      id_q         <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            op_a_q       <= bus.a_in[win_idx*WIDTH +: WIDTH];
            op_b_q       <= bus.b_in[win_idx*WIDTH +: WIDTH];
            op_ctrl_q    <= bus.control_in[win_idx];
            op_id_q      <= win_idx;
            last_grant_q <= win_idx;
            busy_q       <= 1'b1;
            state_q      <= StExec;
          end
        end
        StExec: begin
          sum_q   <= bus.au_sum_in;
          carry_q <= bus.au_carry_in;
          id_q    <= op_id_q;
          valid_q <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          if (bus.result_ready_in) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready_out    = ready;
  assign bus.au_a_out         = op_a_q;
  assign bus.au_b_out         = op_b_q;
  assign bus.au_control_out   = op_ctrl_q;
  assign bus.result_valid_out = valid_q;
  assign bus.sum_out          = sum_q;
  assign bus.carry_out        = carry_q;
  assign bus.result_id_out    = id_q;
  assign bus.busy_out         = busy_q;
endmodule
